// File: rtl/ysyx_22050243_pkg.sv
// Shared opcodes, FSM state type and width default for the EXU slice.
package ysyx_22050243_pkg;

  localparam int XLEN_DEF = 64;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SLL = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b0010;
  localparam logic [3:0] ALU_INV = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } exu_state_t;

endpackage

// File: rtl/ysyx_22050243_MulIter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, XLEN cycles per product.
// Compiled only when YSYX_22050243_MUL_EN is defined.
`ifdef YSYX_22050243_MUL_EN
module ysyx_22050243_MulIter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            abort,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] prod
);
  localparam int CW = $clog2(XLEN);

  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [XLEN-1:0] acc_nxt;

  // done is asserted during the last iteration, so prod must include that bit's add
  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done    = busy_q && (cnt_q == CW'(XLEN-1));
  assign prod    = acc_nxt;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (busy_q) begin
      acc_d    = acc_nxt;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (done) busy_d = 1'b0;
    end
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
    end
    if (abort) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule
`endif

// File: rtl/ysyx_22050243_exu.sv
// Execute unit: ADD/SLL in one cycle, optional iterative MUL (YSYX_22050243_MUL_EN),
// valid/ready on both sides, flush aborts whatever is in flight.
module ysyx_22050243_exu
  import ysyx_22050243_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [4:0]      rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  exu_state_t      state_q, state_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [4:0]      rd_q, rd_d;
  logic            ill_q, ill_d;

  logic            accept, is_mul, dec_ill;
  logic [XLEN-1:0] dec_res;

  assign in_ready    = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept      = in_valid && in_ready && !flush;
  assign out_valid   = (state_q == DONE);
  assign out_result  = res_q;
  assign out_rd      = rd_q;
  assign out_illegal = ill_q;

  always_comb begin
    dec_res = '0;
    dec_ill = 1'b0;
    is_mul  = 1'b0;
    case (alu_ctrl)
      ALU_ADD: dec_res = src1 + src2;
      ALU_SLL: dec_res = src1 << src2[5:0];
`ifdef YSYX_22050243_MUL_EN
      ALU_MUL: is_mul  = 1'b1;
`endif
      default: dec_ill = 1'b1;
    endcase
  end

`ifdef YSYX_22050243_MUL_EN
  logic            mul_done;
  logic [XLEN-1:0] mul_prod;

  ysyx_22050243_MulIter #(.XLEN(XLEN)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .abort (flush),
    .start (accept && is_mul),
    .a     (src1),
    .b     (src2),
    .done  (mul_done),
    .prod  (mul_prod)
  );
`endif

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    rd_d    = rd_q;
    ill_d   = ill_q;
    case (state_q)
      IDLE: state_d = IDLE;
`ifdef YSYX_22050243_MUL_EN
      BUSY: if (mul_done) begin
        state_d = DONE;
        res_d   = mul_prod;
      end
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // a same-cycle accept in DONE overrides the DONE->IDLE drain
    if (accept) begin
      rd_d = rd;
      if (is_mul) begin
        state_d = BUSY;
        ill_d   = 1'b0;
      end else begin
        state_d = DONE;
        res_d   = dec_res;
        ill_d   = dec_ill;
      end
    end
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      rd_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      ill_q   <= ill_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22050243_exu.sv
// Self-checking bench for ysyx_22050243_exu; MUL expectations follow YSYX_22050243_MUL_EN.
module tb_ysyx_22050243_exu;

  localparam int XLEN = 64;
`ifdef YSYX_22050243_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] src1, src2, out_result;
  logic [4:0]      rd, out_rd;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ysyx_22050243_exu #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .src1(src1), .src2(src2), .rd(rd), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd), .out_illegal(out_illegal)
  );

  // reference: {illegal, result} straight from the opcode table
  function automatic logic [XLEN:0] ref_op(input logic [3:0] op, input logic [XLEN-1:0] a, b);
    logic [2*XLEN-1:0] full;
    if (op == 4'b0000) return {1'b0, a + b};
    if (op == 4'b0001) return {1'b0, a << b[5:0]};
    if (op == 4'b0010 && MUL_EN) begin
      full = a * b;
      return {1'b0, full[XLEN-1:0]};
    end
    return {1'b1, {XLEN{1'b0}}};
  endfunction

  function automatic int ref_lat(input logic [3:0] op);
    return (op == 4'b0010 && MUL_EN) ? XLEN : 0;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [XLEN-1:0] a, b, input logic [4:0] r);
    in_valid = 1'b1; alu_ctrl = op; src1 = a; src2 = b; rd = r;
    tick();
    in_valid = 1'b0;
  endtask

  // counts cycles spent waiting for out_valid; flags any in_ready seen meanwhile
  task automatic wait_out(output int n, output bit rdy_seen);
    n = 0; rdy_seen = 1'b0;
    while (!out_valid && n < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      tick(); n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 0; in_valid = 0; out_ready = 1; alu_ctrl = 0; src1 = 0; src2 = 0; rd = 0;
    repeat (3) tick();
    total++;
    if ({out_valid, out_result, out_rd, out_illegal} !== '0) $display("FAIL reset_outs got v=%b r=%h rd=%0d i=%b want 0", out_valid, out_result, out_rd, out_illegal);
    else passed++;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add_wrap();
    issue(4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd5);
    total++;
    if ({out_valid, out_result, out_rd, out_illegal} !== {1'b1, 64'd0, 5'd5, 1'b0})
      $display("FAIL add_wrap got v=%b r=%h rd=%0d i=%b want v=1 r=0 rd=5 i=0", out_valid, out_result, out_rd, out_illegal);
    else passed++;
    tick();
  endtask

  task automatic test_sll_stall();
    bit bad = 0;
    out_ready = 1'b0;
    issue(4'b0001, 64'd1, 64'h47, 5'd9);
    for (int i = 0; i < 3; i++) begin
      if (!out_valid || out_result !== 64'h80 || out_rd !== 5'd9 || in_ready !== 1'b0) bad = 1;
      tick();
    end
    total++;
    if (bad) $display("FAIL sll_stall got v=%b r=%h rdy=%b want v=1 r=80 rdy=0 held", out_valid, out_result, in_ready);
    else passed++;
    out_ready = 1'b1; #1;
    total++;
    if (in_ready !== 1'b1 || out_result !== 64'h80) $display("FAIL sll_release got rdy=%b r=%h want 1 80", in_ready, out_result);
    else passed++;
    tick();
    total++;
    if (out_valid !== 1'b0) $display("FAIL sll_drain got v=%b want 0", out_valid); else passed++;
  endtask

  task automatic test_illegal();
    issue(4'b1111, 64'd3, 64'd4, 5'd2);
    total++;
    if ({out_valid, out_result, out_illegal} !== {1'b1, 64'd0, 1'b1})
      $display("FAIL illegal got v=%b r=%h i=%b want v=1 r=0 i=1", out_valid, out_result, out_illegal);
    else passed++;
    tick();
  endtask

  task automatic test_mul();
    int n; bit rs;
    logic [XLEN:0] e;
    e = ref_op(4'b0010, 64'd7, 64'd6);
    issue(4'b0010, 64'd7, 64'd6, 5'd3);
    wait_out(n, rs);
    total++;
    if (n !== ref_lat(4'b0010) || (n > 0 && rs)) $display("FAIL mul_latency got %0d rdy_seen=%b want %0d rdy_seen=0", n, rs, ref_lat(4'b0010));
    else passed++;
    total++;
    if ({out_valid, out_illegal, out_result} !== {1'b1, e[XLEN], e[XLEN-1:0]})
      $display("FAIL mul_result got v=%b i=%b r=%0d want v=1 i=%b r=%0d", out_valid, out_illegal, out_result, e[XLEN], e[XLEN-1:0]);
    else passed++;
    tick();
  endtask

  task automatic test_flush();
    // flush beats a simultaneous issue
    in_valid = 1; flush = 1; alu_ctrl = 4'b0000; src1 = 1; src2 = 1; rd = 1;
    tick();
    in_valid = 0; flush = 0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL flush_issue got v=%b rdy=%b want 0 1", out_valid, in_ready); else passed++;
    // flush drops a stalled result
    out_ready = 0;
    issue(4'b0000, 64'd8, 64'd9, 5'd4);
    flush = 1; tick(); flush = 0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL flush_done got v=%b rdy=%b want 0 1", out_valid, in_ready); else passed++;
    out_ready = 1;
`ifdef YSYX_22050243_MUL_EN
    issue(4'b0010, 64'd123, 64'd456, 5'd7);
    repeat (9) tick();
    total++;
    if (in_ready !== 1'b0) $display("FAIL flush_busy_pre got rdy=%b want 0", in_ready); else passed++;
    flush = 1; tick(); flush = 0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL flush_busy got v=%b rdy=%b want 0 1", out_valid, in_ready); else passed++;
    begin
      bit seen = 0;
      for (int i = 0; i < 80; i++) begin if (out_valid) seen = 1; tick(); end
      total++;
      if (seen) $display("FAIL flush_busy_ghost got out_valid after flush want none"); else passed++;
    end
`endif
  endtask

  task automatic test_reset_busy();
    int n; bit rs;
    issue(4'b0000, 64'd5, 64'd5, 5'd6);
    out_ready = 0;
`ifdef YSYX_22050243_MUL_EN
    out_ready = 1;
    issue(4'b0010, 64'd11, 64'd13, 5'd8);
    repeat (19) tick();
`endif
    rst_n = 0; #1;
    total++;
    if ({out_valid, out_result, out_rd, out_illegal} !== '0)
      $display("FAIL async_reset got v=%b r=%h rd=%0d i=%b want 0", out_valid, out_result, out_rd, out_illegal);
    else passed++;
    tick(); rst_n = 1; out_ready = 1; tick();
    issue(4'b0000, 64'd2, 64'd2, 5'd1);
    total++;
    if ({out_valid, out_result, out_rd} !== {1'b1, 64'd4, 5'd1}) $display("FAIL post_reset_add got v=%b r=%0d rd=%0d want 1 4 1", out_valid, out_result, out_rd);
    else passed++;
    tick();
    wait_out(n, rs);
    total++;
    if (n != 200) $display("FAIL post_reset_ghost got out_valid after %0d cycles want none", n); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [XLEN:0] e;
    logic [3:0] op;
    logic [4:0] r;
    int bad = 0;
    out_ready = 1;
    for (int i = 0; i < 12; i++) begin
      op = ($urandom_range(0, 2) == 2) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 1));
      in_valid = 1; alu_ctrl = op; src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom}; rd = 5'($urandom);
      e = ref_op(op, src1, src2); r = rd;
      if (in_ready !== 1'b1) bad++;
      tick();
      if ({out_valid, out_illegal, out_result, out_rd} !== {1'b1, e[XLEN], e[XLEN-1:0], r}) begin
        bad++;
        $display("FAIL b2b[%0d] got v=%b i=%b r=%h rd=%0d want v=1 i=%b r=%h rd=%0d", i, out_valid, out_illegal, out_result, out_rd, e[XLEN], e[XLEN-1:0], r);
      end
    end
    in_valid = 0;
    tick();
    total++;
    if (bad != 0) $display("FAIL b2b_summary got %0d bad beats want 0", bad); else passed++;
  endtask

  task automatic test_random();
    logic [XLEN:0] e;
    logic [3:0] op;
    logic [XLEN-1:0] a, b;
    logic [4:0] r;
    int n, k; bit rs, held;
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 4))
        0: op = 4'b0000;
        1: op = 4'b0001;
        2: op = ($urandom_range(0, 3) == 0) ? 4'b0010 : 4'b0000;
        default: op = 4'($urandom_range(2, 15));
      endcase
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; r = 5'($urandom);
      if ($urandom_range(0, 1)) a = 64'($urandom_range(0, 1000));
      e = ref_op(op, a, b);
      out_ready = 0;
      issue(op, a, b, r);
      wait_out(n, rs);
      total++;
      if (n !== ref_lat(op)) $display("FAIL rand[%0d] latency op=%h got %0d want %0d", t, op, n, ref_lat(op));
      else passed++;
      k = $urandom_range(0, 3); held = 1;
      for (int i = 0; i <= k; i++) begin
        if ({out_valid, out_illegal, out_result, out_rd} !== {1'b1, e[XLEN], e[XLEN-1:0], r} || in_ready !== 1'b0) held = 0;
        if (i < k) tick();
      end
      total++;
      if (!held) $display("FAIL rand[%0d] op=%h got v=%b i=%b r=%h rd=%0d want v=1 i=%b r=%h rd=%0d", t, op, out_valid, out_illegal, out_result, out_rd, e[XLEN], e[XLEN-1:0], r);
      else passed++;
      out_ready = 1;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_sll_stall();
    test_illegal();
    test_mul();
    test_flush();
    test_reset_busy();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
